// File: rtl/dmem_stream_reader.sv
// Sequential read engine for data-memory port B: walks a word range and streams it out with backpressure.
// Optional running checksum on `sum` is built only when DMEM_RD_SUM_EN is defined.
module dmem_stream_reader #(
  parameter int DEPTH      = 70000,
  parameter int AW         = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   sum
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic          iss_q, iss_d;
  logic          rd_q, rd_d;
  logic          done_q, done_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic          accept;
  logic          flush;
  logic          issue;
  logic          push;
  logic          pop;
  logic [AW-1:0] base_eff;
  logic [CW:0]   pending;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign base_eff = (32'(base) >= 32'(DEPTH)) ? '0 : base;

  // Credit covers the FIFO plus both pipeline stages (address register, RAM output).
  assign pending = (CW+1)'(count_q) + (CW+1)'(iss_q) + (CW+1)'(rd_q);

  assign accept = (state_q == IDLE) && start && !abort;
  assign flush  = (state_q != IDLE) && abort;
  assign issue  = (state_q == RUN) && (remaining_q != '0) && !abort &&
                  (pending < (CW+1)'(FIFO_DEPTH));
  assign push   = rd_q && !flush;
  assign pop    = (count_q != '0) && out_ready;

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    iss_d       = 1'b0;
    rd_d        = 1'b0;
    done_d      = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (flush) begin
      state_d     = IDLE;
      remaining_d = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
    end else begin
      iss_d = issue;
      rd_d  = iss_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);

      case (state_q)
        IDLE: begin
          if (accept) begin
            if (len == '0) begin
              done_d = 1'b1;
            end else begin
              // Acceptance itself issues the first read so word[base] lands two edges later.
              state_d     = RUN;
              mem_addr_d  = base_eff;
              remaining_d = len - 1'b1;
              iss_d       = 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            mem_addr_d  = addr_inc(mem_addr_q);
            remaining_d = remaining_q - 1'b1;
          end
          if (remaining_d == '0) state_d = DRAIN;
        end
        DRAIN: begin
          if (!iss_q && !rd_q && (count_d == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      iss_q       <= 1'b0;
      rd_q        <= 1'b0;
      done_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      iss_q       <= iss_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_mem[rd_ptr_q];

`ifdef DMEM_RD_SUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept)   sum_d = '0;
    else if (pop) sum_d = sum_q + out_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum = sum_q;
`else
  assign sum = '0;
`endif

endmodule
